// File: rtl/vga_sync_monitor.sv
// vga_sync_monitor: receive-side checker for a VGA sync stream. Measures line
// and frame periods, runs a lock FSM and, once locked, recovers x/y/de.
// Optional blank_b cross-check is built when VGA_MON_BLANK_CHECK_EN is defined.
module vga_sync_monitor #(
  parameter int unsigned H_TOTAL     = 800,
  parameter int unsigned V_TOTAL     = 525,
  parameter int unsigned H_START     = 144,
  parameter int unsigned V_START     = 35,
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic        vgaclk,
  input  logic        rst_n,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        blank_b,
  output logic [9:0]  x,
  output logic [9:0]  y,
  output logic        de,
  output logic        frame_start,
  output logic        locked,
  output logic [10:0] h_total,
  output logic [9:0]  v_total,
  output logic [7:0]  err_count,
  output logic        blank_err
);

  localparam logic [1:0] ST_SEARCH = 2'd0;
  localparam logic [1:0] ST_VERIFY = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  localparam int unsigned GW = (LOCK_FRAMES > 1) ? $clog2(LOCK_FRAMES) : 1;
  localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_FRAMES - 1);

  localparam logic [10:0] H_TOTAL_W = 11'(H_TOTAL);
  localparam logic [9:0]  V_TOTAL_W = 10'(V_TOTAL);
  localparam logic [10:0] HS_LO     = 11'(H_START);
  localparam logic [10:0] HS_HI     = 11'(H_START + H_ACTIVE);
  localparam logic [9:0]  VS_LO     = 10'(V_START);
  localparam logic [9:0]  VS_HI     = 10'(V_START + V_ACTIVE);

  logic          hs_q, vs_q;
  logic          hs_fall, vs_fall;
  logic [10:0]   hcnt_q, hcnt_d, hcnt_p1, hpos;
  logic          h_valid_q, h_valid_d;
  logic [10:0]   h_total_q, h_total_d;
  logic [9:0]    vline_q, vline_d;
  logic [9:0]    v_total_q, v_total_d;
  logic          line_err_q, line_err_d;
  logic          sync_lost, line_error, bad_frame;
  logic [1:0]    state_q, state_d;
  logic [GW-1:0] good_q, good_d;
  logic          lock_loss, blank_inc;
  logic [7:0]    err_count_q, err_count_d;
  logic          win;
  logic [9:0]    x_q, x_d, y_q, y_d;
  logic          de_q, de_d, fs_q, fs_d;

  // Sync edge detection and horizontal/vertical period measurement.
  always_comb begin
    hs_fall    = hs_q & ~hsync;
    vs_fall    = vs_q & ~vsync;
    hcnt_p1    = hcnt_q + 11'd1;
    hpos       = hs_fall ? '0 : hcnt_p1;
    // A falling hsync on the saturated cycle counts as a resync, not a timeout.
    sync_lost  = (hcnt_q == '1) && !hs_fall;
    line_error = hs_fall && h_valid_q && (hcnt_p1 != H_TOTAL_W);
    bad_frame  = (vline_q != V_TOTAL_W) || line_err_q || line_error;

    hcnt_d     = hs_fall ? '0 : ((hcnt_q == '1) ? hcnt_q : hcnt_p1);
    h_valid_d  = hs_fall ? 1'b1 : (sync_lost ? 1'b0 : h_valid_q);
    h_total_d  = (hs_fall && h_valid_q) ? hcnt_p1 : h_total_q;
    vline_d    = vs_fall ? '0 : (hs_fall ? vline_q + 10'd1 : vline_q);
    v_total_d  = vs_fall ? vline_q : v_total_q;
    line_err_d = vs_fall ? 1'b0 : (line_err_q | line_error);
  end

  // Lock state machine and saturating error counter.
  always_comb begin
    state_d   = state_q;
    good_d    = good_q;
    lock_loss = 1'b0;
    case (state_q)
      ST_SEARCH: begin
        if (vs_fall) begin
          state_d = ST_VERIFY;
          good_d  = '0;
        end
      end
      ST_VERIFY: begin
        if (vs_fall) begin
          if (bad_frame) begin
            good_d = '0;
          end else if (good_q == GOOD_LAST) begin
            state_d = ST_LOCKED;
            good_d  = '0;
          end else begin
            good_d = good_q + 1'b1;
          end
        end
      end
      ST_LOCKED: begin
        if (line_error || (vs_fall && bad_frame)) begin
          state_d   = ST_VERIFY;
          good_d    = '0;
          lock_loss = 1'b1;
        end
      end
      default: begin
        state_d = ST_SEARCH;
        good_d  = '0;
      end
    endcase
    if (sync_lost) begin
      state_d   = ST_SEARCH;
      good_d    = '0;
      lock_loss = (state_q == ST_LOCKED);
    end
    err_count_d = err_count_q;
    if ((lock_loss || blank_inc) && (err_count_q != '1)) begin
      err_count_d = err_count_q + 8'd1;
    end
  end

  // Active-window recovery feeding the registered coordinate outputs.
  always_comb begin
    win  = (state_q == ST_LOCKED) &&
           (hpos >= HS_LO) && (hpos < HS_HI) &&
           (vline_q >= VS_LO) && (vline_q < VS_HI);
    de_d = win;
    x_d  = win ? 10'(hpos - HS_LO) : '0;
    y_d  = win ? (vline_q - VS_LO) : '0;
    fs_d = (state_q == ST_LOCKED) && vs_fall;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge vgaclk) begin
    if (!rst_n) begin
      hs_q        <= 1'b0;
      vs_q        <= 1'b0;
      hcnt_q      <= '0;
      h_valid_q   <= 1'b0;
      h_total_q   <= '0;
      vline_q     <= '0;
      v_total_q   <= '0;
      line_err_q  <= 1'b0;
      state_q     <= ST_SEARCH;
      good_q      <= '0;
      err_count_q <= '0;
      x_q         <= '0;
      y_q         <= '0;
      de_q        <= 1'b0;
      fs_q        <= 1'b0;
    end else begin
      hs_q        <= hsync;
      vs_q        <= vsync;
      hcnt_q      <= hcnt_d;
      h_valid_q   <= h_valid_d;
      h_total_q   <= h_total_d;
      vline_q     <= vline_d;
      v_total_q   <= v_total_d;
      line_err_q  <= line_err_d;
      state_q     <= state_d;
      good_q      <= good_d;
      err_count_q <= err_count_d;
      x_q         <= x_d;
      y_q         <= y_d;
      de_q        <= de_d;
      fs_q        <= fs_d;
    end
  end

`ifdef VGA_MON_BLANK_CHECK_EN
  logic mismatch, blank_seen_q, blank_seen_d, blank_err_q, blank_err_d;

  // blank_b versus recovered window; one error count per offending line.
  always_comb begin
    mismatch     = (state_q == ST_LOCKED) && (blank_b != win);
    blank_inc    = mismatch && (hs_fall || !blank_seen_q);
    blank_seen_d = hs_fall ? mismatch : (blank_seen_q | mismatch);
    blank_err_d  = blank_err_q | mismatch;
  end

  // Blank-check flags; blank_err is sticky until reset.
  always_ff @(posedge vgaclk) begin
    if (!rst_n) begin
      blank_seen_q <= 1'b0;
      blank_err_q  <= 1'b0;
    end else begin
      blank_seen_q <= blank_seen_d;
      blank_err_q  <= blank_err_d;
    end
  end

  assign blank_err = blank_err_q;
`else
  logic unused_blank;
  assign unused_blank = blank_b;
  assign blank_inc    = 1'b0;
  assign blank_err    = 1'b0;
`endif

  assign x           = x_q;
  assign y           = y_q;
  assign de          = de_q;
  assign frame_start = fs_q;
  assign locked      = (state_q == ST_LOCKED);
  assign h_total     = h_total_q;
  assign v_total     = v_total_q;
  assign err_count   = err_count_q;

endmodule

// File: tb/tb_vga_sync_monitor.sv
// tb_vga_sync_monitor: directed bench for vga_sync_monitor using a scaled
// 100x30 timing (20/64 horizontal, 3/24 vertical) so several frames fit.
module tb_vga_sync_monitor;

  localparam int HT  = 100;
  localparam int HS  = 20;
  localparam int HA  = 64;
  localparam int VT  = 30;
  localparam int VS  = 3;
  localparam int VA  = 24;
  localparam int HSW = 12;
`ifdef VGA_MON_BLANK_CHECK_EN
  localparam int BLANK_EN = 1;
`else
  localparam int BLANK_EN = 0;
`endif

  logic        vgaclk = 1'b0;
  logic        rst_n, hsync, vsync, blank_b;
  logic [9:0]  x, y, v_total;
  logic        de, frame_start, locked, blank_err;
  logic [10:0] h_total;
  logic [7:0]  err_count;

  vga_sync_monitor #(
    .H_TOTAL(HT), .V_TOTAL(VT), .H_START(HS), .V_START(VS),
    .H_ACTIVE(HA), .V_ACTIVE(VA), .LOCK_FRAMES(2)
  ) dut (
    .vgaclk(vgaclk), .rst_n(rst_n), .hsync(hsync), .vsync(vsync),
    .blank_b(blank_b), .x(x), .y(y), .de(de), .frame_start(frame_start),
    .locked(locked), .h_total(h_total), .v_total(v_total),
    .err_count(err_count), .blank_err(blank_err)
  );

  always #5 vgaclk = ~vgaclk;

  typedef struct {
    int v;
    int h;
    int ex;
    int ey;
    int ede;
    int efs;
  } vec_t;

  vec_t vecs[10];
  int gv, gh, lv, lh;
  int stretch_v, force_v, force_h1, force_h2;
  int n_pass, n_total;

  task automatic check(input string name, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_x"}, x, 0);
    check({tag, "_y"}, y, 0);
    check({tag, "_de"}, de, 0);
    check({tag, "_fs"}, frame_start, 0);
    check({tag, "_locked"}, locked, 0);
    check({tag, "_h_total"}, h_total, 0);
    check({tag, "_v_total"}, v_total, 0);
    check({tag, "_err"}, err_count, 0);
    check({tag, "_blank_err"}, blank_err, 0);
  endtask

  // Drive one pixel of the stream at (gv,gh), then sample 1 ns after the edge.
  task automatic pix();
    int lin;
    @(negedge vgaclk);
    lin     = gv * HT + gh;
    hsync   = !(gh < HSW);
    vsync   = !(lin >= 1 && lin <= HT);
    blank_b = (gh >= HS) && (gh < HS + HA) && (gv >= VS) && (gv < VS + VA);
    if (gv == force_v && (gh == force_h1 || gh == force_h2)) blank_b = 1'b0;
    lv = gv;
    lh = gh;
    gh++;
    if (gh >= ((gv == stretch_v) ? HT + 1 : HT)) begin
      gh = 0;
      gv = (gv + 1) % VT;
    end
    @(posedge vgaclk);
    #1;
  endtask

  task automatic run_to(input int tv, input int th);
    int n;
    n = 0;
    do begin
      pix();
      n++;
    end while (!(lv == tv && lh == th) && n < 4000);
    if (!(lv == tv && lh == th)) begin
      n_total++;
      $display("FAIL run_to_%0d_%0d: got timeout after %0d cycles expected position reached", tv, th, n);
    end
  endtask

  task automatic hold_syncs(input int cycles);
    for (int unsigned i = 0; i < cycles; i++) begin
      @(negedge vgaclk);
      hsync   = 1'b1;
      vsync   = 1'b1;
      blank_b = 1'b0;
      @(posedge vgaclk);
      #1;
    end
  endtask

  task automatic relock(input string tag, input int exp_err);
    run_to(0, 1);
    check({tag, "_vs1_locked"}, locked, 0);
    run_to(0, 1);
    check({tag, "_vs2_locked"}, locked, 0);
    run_to(0, 1);
    check({tag, "_vs3_locked"}, locked, 1);
    check({tag, "_h_total"}, h_total, HT);
    check({tag, "_v_total"}, v_total, VT);
    check({tag, "_err"}, err_count, exp_err);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got time limit expected test completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{3, 19, 0, 0, 0, 0};
    vecs[1] = '{3, 20, 0, 0, 1, 0};
    vecs[2] = '{15, 40, 20, 12, 1, 0};
    vecs[3] = '{26, 83, 63, 23, 1, 0};
    vecs[4] = '{26, 84, 0, 0, 0, 0};
    vecs[5] = '{27, 50, 0, 0, 0, 0};
    vecs[6] = '{0, 0, 0, 0, 0, 0};
    vecs[7] = '{0, 1, 0, 0, 0, 1};
    vecs[8] = '{0, 2, 0, 0, 0, 0};
    vecs[9] = '{2, 50, 0, 0, 0, 0};

    n_pass = 0; n_total = 0;
    gv = 0; gh = 0; lv = -1; lh = -1;
    stretch_v = -1; force_v = -1; force_h1 = -1; force_h2 = -1;
    hsync = 1'b1; vsync = 1'b1; blank_b = 1'b0; rst_n = 1'b0;

    // Reset state, then lock from a nominal stream.
    repeat (5) pix();
    check_zero("reset");
    rst_n = 1'b1;
    run_to(0, 1);
    check("init_vs1_locked", locked, 0);
    run_to(0, 1);
    check("init_vs2_locked", locked, 0);
    run_to(0, 0);
    check("init_pre_vs3_locked", locked, 0);
    run_to(0, 1);
    check("init_vs3_locked", locked, 1);
    check("init_h_total", h_total, HT);
    check("init_v_total", v_total, VT);
    check("init_err", err_count, 0);
    check("init_blank_err", blank_err, 0);

    // Coordinate corners and frame_start width.
    for (int unsigned i = 0; i < 10; i++) begin
      run_to(vecs[i].v, vecs[i].h);
      check($sformatf("vec%0d_x", i), x, vecs[i].ex);
      check($sformatf("vec%0d_y", i), y, vecs[i].ey);
      check($sformatf("vec%0d_de", i), de, vecs[i].ede);
      check($sformatf("vec%0d_fs", i), frame_start, vecs[i].efs);
      check($sformatf("vec%0d_locked", i), locked, 1);
    end

    // One line stretched to HT+1 clocks.
    stretch_v = 10;
    run_to(10, HT);
    check("stretch_pre_locked", locked, 1);
    run_to(11, 0);
    stretch_v = -1;
    check("stretch_h_total", h_total, HT + 1);
    check("stretch_err", err_count, 1);
    check("stretch_locked", locked, 0);
    run_to(12, 0);
    check("stretch_next_h_total", h_total, HT);
    relock("stretch_relock", 1);

    // hsync stuck high long enough to saturate the line counter.
    run_to(5, HT - 1);
    hold_syncs(2048);
    check("stall_locked", locked, 0);
    check("stall_err", err_count, 2);
    check("stall_h_total", h_total, HT);
    gv = 0; gh = 0;
    run_to(0, 0);
    check("stall_first_fall_h_total", h_total, HT);
    relock("stall_relock", 2);

    // Reset mid-frame while locked.
    run_to(15, 40);
    check("midreset_pre_de", de, 1);
    rst_n = 1'b0;
    pix();
    check_zero("midreset");
    rst_n = 1'b1;
    relock("midreset_relock", 0);

    // blank_b dropped at active pixel (10,20), and again later on the same line.
    force_v = VS + 20; force_h1 = HS + 10; force_h2 = HS + 20;
    run_to(VS + 20, HS + 9);
    check("blank_pre_flag", blank_err, 0);
    check("blank_pre_err", err_count, 0);
    run_to(VS + 20, HS + 10);
    check("blank_flag", blank_err, BLANK_EN);
    check("blank_err", err_count, BLANK_EN);
    check("blank_x", x, 10);
    check("blank_y", y, 20);
    run_to(VS + 21, 1);
    force_v = -1;
    check("blank_line_err", err_count, BLANK_EN);
    check("blank_sticky", blank_err, BLANK_EN);
    check("blank_locked", locked, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
